// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready on both sides.
// in_ready and out_valid are flop outputs, so neither side sees a combinational path.
module pipe_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign out_data = main_q;

  // Handshake flags and occupancy are registered alongside the state so they never
  // depend on the current cycle's in_valid / out_ready.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            main_q    <= in_data;
            state     <= BUSY;
            out_valid <= 1'b1;
            count     <= 2'd1;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            main_q <= in_data;
          end else if (in_valid) begin
            skid_q   <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
            count    <= 2'd2;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            count     <= 2'd0;
          end
        end
        FULL: begin
          // Upstream is stalled here, so only a downstream consume can move data.
          if (out_ready) begin
            main_q   <= skid_q;
            state    <= BUSY;
            in_ready <= 1'b1;
            count    <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          count     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: a queue-based model of a depth-2 FIFO
// feeds a scoreboard that a separate negedge monitor drains.
module tb_pipe_skid_buffer;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  always #5 clk = ~clk;

  pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] exp_head = '0;
  bit               checking = 1'b0;
  bit               last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: the buffer is a FIFO of capacity 2 that accepts whenever it
  // held fewer than 2 words at the start of the cycle.
  always @(posedge clk) begin
    bit acc;
    acc = in_valid && !reset && !flush && (mq.size() < 2);
    last_acc = acc;
    if (reset || flush) begin
      mq.delete();
      sb.delete();
      exp_head = '0;
      if (reset) checking = 1'b1;
    end else begin
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(in_data);
        sb.push_back(in_data);
      end
      if (mq.size() > 0) exp_head = mq[0];
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("count", {30'd0, count}, mq.size());
      chk("in_ready", {31'd0, in_ready}, {31'd0, (mq.size() < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
      if (out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_word: got %0h, expected no word", out_data);
        end else begin
          chk("out_data", {24'd0, out_data}, {24'd0, sb[0]});
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("idle_data", {24'd0, out_data}, {24'd0, exp_head});
      end
    end
  end

  task automatic cyc(input bit iv, input logic [WIDTH-1:0] d, input bit ordy,
                     input bit fl = 1'b0, input bit rs = 1'b0);
    in_valid  = iv;
    in_data   = d;
    out_ready = rs ? 1'b0 : ordy;
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit               offered;
    bit               iv;
    logic [WIDTH-1:0] d;

    // Reset then idle
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0);

    // Streaming
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 8'(i), 1'b1);
      chk("stream_data", {24'd0, out_data}, i);
    end
    cyc(1'b0, 8'h00, 1'b1);

    // Stall absorption
    cyc(1'b1, 8'hA1, 1'b1);
    cyc(1'b1, 8'hA2, 1'b0);
    chk("stall_count", {30'd0, count}, 32'd2);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(1'b1, 8'hA3, 1'b0);
    cyc(1'b1, 8'hA3, 1'b0);
    cyc(1'b1, 8'hA3, 1'b1);
    chk("stall_second", {24'd0, out_data}, 32'hA2);
    cyc(1'b1, 8'hA3, 1'b1);
    chk("stall_third", {24'd0, out_data}, 32'hA3);
    cyc(1'b0, 8'h00, 1'b1);

    // Simultaneous in/out in BUSY
    cyc(1'b1, 8'h10, 1'b0);
    cyc(1'b1, 8'h20, 1'b1);
    chk("pass_data", {24'd0, out_data}, 32'h20);
    chk("pass_count", {30'd0, count}, 32'd1);
    cyc(1'b0, 8'h00, 1'b1);

    // Flush while FULL
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h66, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush_count", {30'd0, count}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_data", {24'd0, out_data}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1);

    // Reset mid-stream
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b1);
    cyc(1'b1, 8'h05, 1'b1, 1'b0, 1'b1);
    chk("mrst_count", {30'd0, count}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_data", {24'd0, out_data}, 32'd0);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b1);
    cyc(1'b0, 8'h00, 1'b1);

    // Randomized traffic; a refused offer is held until accepted
    offered = 1'b0;
    d = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!(offered && !last_acc)) begin
        iv = ($urandom % 4) != 0;
        d  = 8'($urandom);
      end else begin
        iv = 1'b1;
      end
      offered = iv;
      cyc(iv, d, ($urandom % 3) != 0, ($urandom % 64) == 0, ($urandom % 256) == 0);
    end
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
